// File: rtl/pulse_pkg.sv
// Shared constants for the pulse edge capture monitor: entry layout, FSM encoding
// and the bit positions of the three monitored lines inside the edge masks.
package pulse_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int ENTRY_W   = 6 + CNT_W_DEF;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ARMED   = 2'd1;
    localparam state_t CAPTURE = 2'd2;
    localparam state_t DONE    = 2'd3;

    localparam int SYNC_B  = 0;
    localparam int PULSE_B = 1;
    localparam int INHIB_B = 2;

    function automatic int entry_width(input int cnt_w);
        return 6 + cnt_w;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Show-ahead FIFO: the head entry is held in a register so rd_data is valid
// whenever the FIFO is non-empty and clears to zero on reset or flush.
module capture_fifo #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 38
) (
    input  logic                     clk_pll,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic                     rd,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [AW:0]        count_reg, count_next;
    logic [ENTRY_W-1:0] head_reg, head_next;
    logic               wr_ok, rd_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign rd_ok   = rd & ~empty & ~flush;
    // A full FIFO still accepts a write when the head is popped on the same edge.
    assign wr_ok   = wr & ~flush & (~full | rd_ok);
    assign rd_data = head_reg;
    assign count   = count_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + AW'(wr_ok);
        rd_ptr_next = rd_ptr_reg + AW'(rd_ok);
        count_next  = count_reg + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
        // The new head is either already in memory or is being written right now.
        if (count_next == '0)
            head_next = '0;
        else if (wr_ok && (wr_ptr_reg == rd_ptr_next))
            head_next = wr_data;
        else
            head_next = mem[rd_ptr_next];
    end

    always_ff @(posedge clk_pll or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    always_ff @(posedge clk_pll) begin
        if (wr_ok)
            mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/pulse_edge_capture.sv
// Timestamps edges on the looped-back sync/pulse/inhib lines relative to the
// sync rising edge for one armed cycle, and queues them for host readback.
module pulse_edge_capture
    import pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = 16
) (
    input  logic                   clk_pll,
    input  logic                   reset,
    input  logic                   sync_in,
    input  logic                   pulse_in,
    input  logic                   inhib_in,
    input  logic                   arm,
    input  logic [CNT_W-1:0]       timeout,
    input  logic                   rd_en,
    output logic [5+CNT_W:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   done
);
    localparam int EW = entry_width(CNT_W);

    logic [2:0]       raw;
    logic [2:0]       meta_reg, sync_reg, hist_reg;
    logic [2:0]       rise, fall;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] ts_reg, ts_next;
    logic             overflow_reg;
    logic             fifo_wr, fifo_full, fifo_empty, drop;
    logic [EW-1:0]    wr_data;

    assign raw = {inhib_in, pulse_in, sync_in};

    // Identical pipelines on all three lines, so the latency cancels in timestamps.
    always_ff @(posedge clk_pll or negedge reset) begin
        if (!reset) begin
            meta_reg <= '0;
            sync_reg <= '0;
            hist_reg <= '0;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
            hist_reg <= sync_reg;
        end
    end

    assign rise    = sync_reg & ~hist_reg;
    assign fall    = ~sync_reg & hist_reg;
    assign wr_data = {rise, fall, ts_reg};

    always_comb begin
        state_next = state_reg;
        ts_next    = ts_reg;
        fifo_wr    = 1'b0;
        case (state_reg)
            ARMED: begin
                if (rise[SYNC_B]) begin
                    state_next = CAPTURE;
                    ts_next    = CNT_W'(1);
                    fifo_wr    = 1'b1;
                end
            end
            CAPTURE: begin
                // The closing sync rise ends the window and is itself not logged.
                if (rise[SYNC_B]) begin
                    state_next = DONE;
                end else begin
                    fifo_wr = |{rise, fall};
                    if ((timeout != '0) && (ts_reg == timeout))
                        state_next = DONE;
                    ts_next = (&ts_reg) ? ts_reg : ts_reg + CNT_W'(1);
                end
            end
            default: ;
        endcase
        if (arm) begin
            state_next = ARMED;
            ts_next    = '0;
            fifo_wr    = 1'b0;
        end
    end

    assign drop = fifo_wr & fifo_full & ~(rd_en & ~fifo_empty);

    always_ff @(posedge clk_pll or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            ts_reg       <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ts_reg    <= ts_next;
            if (arm)
                overflow_reg <= 1'b0;
            else if (drop)
                overflow_reg <= 1'b1;
        end
    end

    capture_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (EW)
    ) u_fifo (
        .clk_pll (clk_pll),
        .reset   (reset),
        .flush   (arm),
        .wr      (fifo_wr),
        .wr_data (wr_data),
        .rd      (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rd_valid = ~fifo_empty;
    assign overflow = overflow_reg;
    assign busy     = (state_reg == ARMED) || (state_reg == CAPTURE);
    assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_pulse_edge_capture.sv
// Directed bench for pulse_edge_capture: expected entries are queued as edges are
// driven and compared as the host pops them.
module tb_pulse_edge_capture;
    localparam int CNT_W = 32;
    localparam int DEPTH = 16;
    localparam int EW    = 6 + CNT_W;

    logic             clk_pll = 1'b0;
    logic             reset;
    logic             sync_in, pulse_in, inhib_in, arm, rd_en;
    logic [CNT_W-1:0] timeout;
    logic [EW-1:0]    rd_data;
    logic             rd_valid, overflow, busy, done;
    logic [4:0]       fifo_count;

    int n_asserts = 0;
    int n_fail    = 0;
    int cur       = 0;
    logic [EW-1:0] exp_q [$];

    always #5 clk_pll = ~clk_pll;

    pulse_edge_capture #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk_pll    (clk_pll),
        .reset      (reset),
        .sync_in    (sync_in),
        .pulse_in   (pulse_in),
        .inhib_in   (inhib_in),
        .arm        (arm),
        .timeout    (timeout),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk_pll);
        #1;
        cur++;
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    task automatic go_to(input int t);
        while (cur < t) tick();
    endtask

    task automatic push(input logic [2:0] r, input logic [2:0] f, input int t);
        exp_q.push_back({r, f, CNT_W'(t)});
    endtask

    task automatic arm_once;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Arm, let sync settle low, then raise it; cur counts ticks from that rise.
    task automatic start_capture;
        arm_once();
        sync_in = 1'b0;
        step(5);
        cur = 0;
        sync_in = 1'b1;
        push(3'b001, 3'b000, 0);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL %s: observed entry 0x%0h expected no entry", tag, rd_data);
        end else begin
            check(tag, 64'(rd_data), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 4 * DEPTH && rd_valid; k++) begin
            pop_check(tag);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        check({tag, " leftover"}, 64'(rd_valid), 64'(0));
        check({tag, " missing"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; sync_in = 1'b0; pulse_in = 1'b0; inhib_in = 1'b0;
        arm = 1'b0; rd_en = 1'b0; timeout = '0;

        // Reset state
        step(3);
        check("rst rd_data", 64'(rd_data), 64'(0));
        check("rst rd_valid", 64'(rd_valid), 64'(0));
        check("rst count", 64'(fifo_count), 64'(0));
        check("rst overflow", 64'(overflow), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        @(negedge clk_pll);
        reset = 1'b1;

        // 1: edge sequence; pulse rises together with sync and shares its entry
        inhib_in = 1'b1;
        step(5);
        arm_once();
        step(4);
        cur = 0;
        sync_in = 1'b1; pulse_in = 1'b1; push(3'b011, 3'b000, 0);
        go_to(40);  pulse_in = 1'b0; push(3'b000, 3'b010, 40);
        go_to(100); pulse_in = 1'b1; push(3'b010, 3'b000, 100);
        go_to(120); pulse_in = 1'b0; sync_in = 1'b0; push(3'b000, 3'b011, 120);
        go_to(200); inhib_in = 1'b0; push(3'b000, 3'b100, 200);
        go_to(205);
        check("t1 busy", 64'(busy), 64'(1));
        check("t1 count", 64'(fifo_count), 64'(5));
        go_to(1000); sync_in = 1'b1;
        go_to(1004);
        check("t1 done", 64'(done), 64'(1));
        check("t1 busy after", 64'(busy), 64'(0));
        drain("t1 entry");

        // 2: timeout window, edge at ts==timeout kept, next one dropped
        timeout = CNT_W'(50);
        start_capture();
        go_to(50); pulse_in = 1'b1; push(3'b010, 3'b000, 50);
        go_to(51); inhib_in = 1'b1;
        go_to(52);
        check("t2 done early", 64'(done), 64'(0));
        go_to(53);
        check("t2 done", 64'(done), 64'(1));
        step(4);
        drain("t2 entry");
        timeout = '0;

        // 3: overflow with 40 toggles and no reads
        arm_once();
        pulse_in = 1'b0; inhib_in = 1'b0;
        start_capture();
        for (int i = 1; i <= 40; i++) begin
            go_to(i);
            pulse_in = ~pulse_in;
            if (exp_q.size() < DEPTH)
                push(pulse_in ? 3'b010 : 3'b000, pulse_in ? 3'b000 : 3'b010, i);
        end
        go_to(45);
        check("t3 count", 64'(fifo_count), 64'(16));
        check("t3 overflow", 64'(overflow), 64'(1));
        drain("t3 entry");
        check("t3 overflow sticky", 64'(overflow), 64'(1));
        arm_once();
        check("t3 arm count", 64'(fifo_count), 64'(0));
        check("t3 arm overflow", 64'(overflow), 64'(0));

        // 4: pop and write on the same edge while full
        start_capture();
        for (int i = 1; i <= 15; i++) begin
            go_to(i);
            pulse_in = ~pulse_in;
            push(pulse_in ? 3'b010 : 3'b000, pulse_in ? 3'b000 : 3'b010, i);
        end
        go_to(20);
        check("t4 full count", 64'(fifo_count), 64'(16));
        check("t4 full overflow", 64'(overflow), 64'(0));
        go_to(30); pulse_in = ~pulse_in;
        push(pulse_in ? 3'b010 : 3'b000, pulse_in ? 3'b000 : 3'b010, 30);
        go_to(32);
        pop_check("t4 head");
        rd_en = 1'b1;
        go_to(33);
        rd_en = 1'b0;
        check("t4 count", 64'(fifo_count), 64'(16));
        check("t4 overflow", 64'(overflow), 64'(0));
        drain("t4 entry");
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t4 empty pop count", 64'(fifo_count), 64'(0));

        // 5: re-arm in the middle of a capture
        start_capture();
        go_to(10); pulse_in = ~pulse_in;
        go_to(30);
        arm_once();
        exp_q.delete();
        check("t5 rd_valid", 64'(rd_valid), 64'(0));
        check("t5 count", 64'(fifo_count), 64'(0));
        check("t5 busy", 64'(busy), 64'(1));
        sync_in = 1'b0;
        step(5);
        sync_in = 1'b1;
        push(3'b001, 3'b000, 0);
        step(5);
        check("t5 new count", 64'(fifo_count), 64'(1));
        drain("t5 entry");

        // 6: asynchronous reset between edges during capture
        start_capture();
        go_to(10); pulse_in = ~pulse_in;
        go_to(77);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("t6 rd_data", 64'(rd_data), 64'(0));
        check("t6 rd_valid", 64'(rd_valid), 64'(0));
        check("t6 count", 64'(fifo_count), 64'(0));
        check("t6 overflow", 64'(overflow), 64'(0));
        check("t6 busy", 64'(busy), 64'(0));
        check("t6 done", 64'(done), 64'(0));
        step(2);
        @(negedge clk_pll);
        reset = 1'b1;
        sync_in = 1'b0;
        step(4);
        sync_in = 1'b1; pulse_in = ~pulse_in;
        step(6);
        check("t6 idle count", 64'(fifo_count), 64'(0));
        check("t6 idle busy", 64'(busy), 64'(0));
        check("t6 idle done", 64'(done), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
